param_entry: RTL

Pushbutton entry controller that produces the three 7-bit run-time values shown on the seven-segment bank: `freq_num`, `seq_num` and `rom_addr`. It synchronizes and debounces the DE2 keys and selects one field at a time. Inc/dec steps with wrap and auto-repeat update the selected field. Outputs connect directly to the display block's `freq_num`/`seq_num`/`rom_addr` inputs and to the top-level datapath.

---
 rtl/param_entry.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/param_entry.sv
// Pushbutton entry for the freq/seq/addr display fields.
// Per-key sync and debounce, field select, inc/dec with wrap and auto-repeat.
module param_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int FREQ_MAX        = 99,
    parameter int SEQ_MAX         = 99,
    parameter int ADDR_MAX        = 127
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic       KEY3,
    output logic [6:0] freq_num,
    output logic [6:0] seq_num,
    output logic [6:0] rom_addr,
    output logic [1:0] sel,
    output logic       upd
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HM = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW = $clog2(HM + 1);

    logic [2:0]    raw;
    logic [2:0]    s1_q, s1_d, s2_q, s2_d, db_q, db_d;
    logic [DW-1:0] cnt_q [3];
    logic [DW-1:0] cnt_d [3];
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          inc_q, inc_d, dec_q, dec_d;
    logic          k3p_q, k3p_d;
    logic [1:0]    sel_q, sel_d;
    logic [6:0]    freq_q, freq_d, seq_q, seq_d, addr_q, addr_d;
    logic          upd_q, upd_d;
    logic          step, up;

    // Bit 0 = dec, bit 1 = inc, bit 2 = select; all active-low.
    assign raw = {KEY3, KEY2, KEY1};

    function automatic logic [6:0] bump(input logic [6:0] v,
                                        input logic [6:0] mx,
                                        input logic       inc);
        if (inc)
            return (v == mx) ? 7'd0 : v + 7'd1;
        return (v == 7'd0) ? mx : v - 7'd1;
    endfunction

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
                    db_d[i] = s2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // A key counts as "solo" only while the other step key is released,
    // so a both-pressed interval restarts the press/hold sequence.
    always_comb begin
        inc_d  = ~db_q[1] & db_q[0];
        dec_d  = ~db_q[0] & db_q[1];
        up     = inc_d;
        step   = 1'b0;
        hold_d = '0;
        rep_d  = 1'b0;
        if ((inc_d & ~inc_q) | (dec_d & ~dec_q)) begin
            step = 1'b1;
        end else if (inc_d | dec_d) begin
            rep_d = rep_q;
            if (hold_q == (rep_q ? HW'(REPEAT_CYCLES - 1) : HW'(HOLD_CYCLES - 1))) begin
                step  = 1'b1;
                rep_d = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end

        freq_d = freq_q;
        seq_d  = seq_q;
        addr_d = addr_q;
        if (step) begin
            case (sel_q)
                2'd0:    freq_d = bump(freq_q, 7'(FREQ_MAX), up);
                2'd1:    seq_d  = bump(seq_q, 7'(SEQ_MAX), up);
                2'd2:    addr_d = bump(addr_q, 7'(ADDR_MAX), up);
                default: ;
            endcase
        end
        upd_d = (freq_d != freq_q) | (seq_d != seq_q) | (addr_d != addr_q);

        k3p_d = db_q[2];
        sel_d = sel_q;
        if (!db_q[2] && k3p_q)
            sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_q   <= '1;
            s2_q   <= '1;
            db_q   <= '1;
            for (int i = 0; i < 3; i++)
                cnt_q[i] <= '0;
            hold_q <= '0;
            rep_q  <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            k3p_q  <= 1'b1;
            sel_q  <= 2'd0;
            freq_q <= 7'd0;
            seq_q  <= 7'd0;
            addr_q <= 7'd0;
            upd_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            db_q   <= db_d;
            for (int i = 0; i < 3; i++)
                cnt_q[i] <= cnt_d[i];
            hold_q <= hold_d;
            rep_q  <= rep_d;
            inc_q  <= inc_d;
            dec_q  <= dec_d;
            k3p_q  <= k3p_d;
            sel_q  <= sel_d;
            freq_q <= freq_d;
            seq_q  <= seq_d;
            addr_q <= addr_d;
            upd_q  <= upd_d;
        end
    end

    assign freq_num = freq_q;
    assign seq_num  = seq_q;
    assign rom_addr = addr_q;
    assign sel      = sel_q;
    assign upd      = upd_q;

endmodule
